// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage F/D/E/M/W pipeline: forwarding selects,
// per-register stall/flush, and sequencing of iterative multiplies and wait-stated memory.
module pipeline_hazard_ctrl #(
    parameter int REG_BITS    = 4,
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int ZERO_REG    = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [REG_BITS-1:0] RsD,
    input  logic [REG_BITS-1:0] RtD,
    input  logic [REG_BITS-1:0] RsE,
    input  logic [REG_BITS-1:0] RtE,
    input  logic [REG_BITS-1:0] WriteRegE,
    input  logic [REG_BITS-1:0] WriteRegM,
    input  logic [REG_BITS-1:0] WriteRegW,
    input  logic                RegWriteE,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic                MemToRegE,
    input  logic                BranchTakenE,
    input  logic                MulStartE,
    input  logic                MemReqM,
    input  logic                MemReadyM,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                StallM,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushM,
    output logic                FlushW,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                MulDone,
    output logic                MemErr
);

    localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int MEM_W = $clog2(MEM_TIMEOUT + 1);
    localparam int CNT_W = (MUL_W > MEM_W) ? MUL_W : MEM_W;

    typedef enum logic [1:0] {IDLE, MULWAIT, MEMWAIT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             mem_err, mem_err_next;
    logic             mem_wait_start;
    logic             load_use;

    function automatic logic reg_match(input logic [REG_BITS-1:0] idx,
                                       input logic [REG_BITS-1:0] dest,
                                       input logic                we);
        return we && (idx == dest) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            count   <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            mem_err <= mem_err_next;
        end
    end

    assign MemErr = mem_err;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!RST) begin
            if (reg_match(RsE, WriteRegM, RegWriteM))      ForwardAE = 2'b10;
            else if (reg_match(RsE, WriteRegW, RegWriteW)) ForwardAE = 2'b01;
            if (reg_match(RtE, WriteRegM, RegWriteM))      ForwardBE = 2'b10;
            else if (reg_match(RtE, WriteRegW, RegWriteW)) ForwardBE = 2'b01;
        end
    end

    assign mem_wait_start = MemReqM && !MemReadyM && !mem_err && (state != MEMWAIT);
    assign load_use = MemToRegE &&
                      (reg_match(RsD, WriteRegE, RegWriteE) || reg_match(RtD, WriteRegE, RegWriteE));

    // Multi-cycle events are resolved first; branch and load-use only act when E is free to move.
    always_comb begin
        state_next   = state;
        count_next   = count;
        mem_err_next = mem_err;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        FlushW       = 1'b0;
        MulDone      = 1'b0;

        if (RST) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (mem_wait_start) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW     = 1'b1;
            state_next = MEMWAIT;
            count_next = CNT_W'(1);
        end else if (state == MEMWAIT) begin
            if (MemReadyM) begin
                state_next = IDLE;
            end else if (count == CNT_W'(MEM_TIMEOUT)) begin
                mem_err_next = 1'b1;
                state_next   = IDLE;
            end else begin
                {StallF, StallD, StallE, StallM} = 4'b1111;
                FlushW     = 1'b1;
                count_next = count + CNT_W'(1);
            end
        end else if (state == MULWAIT) begin
            {StallF, StallD, StallE} = 3'b111;
            FlushM = 1'b1;
            if (count == '0) begin
                MulDone    = 1'b1;
                state_next = IDLE;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end else if (MulStartE) begin
            {StallF, StallD, StallE} = 3'b111;
            FlushM     = 1'b1;
            state_next = MULWAIT;
            count_next = CNT_W'(MUL_LAT - 2);
        end

        // A taken branch squashes D and E, which also disposes of any load-use consumer in D.
        if (!RST && !StallE) begin
            if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (state == IDLE && load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a cycle-count based reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_BITS    = 4;
    localparam int MUL_LAT     = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int ZERO_REG    = 1;

    logic CLK = 1'b0;
    logic RST;
    logic [REG_BITS-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE, MulStartE, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic MulDone, MemErr;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(
        .REG_BITS(REG_BITS), .MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .ZERO_REG(ZERO_REG)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDone(MulDone), .MemErr(MemErr)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the multiply is tracked as "cycles still to stall", the memory
    // access as "wait cycles already spent", plus the sticky error bit.
    int   m_mul_left = 0, m_mem_cycles = 0, n_mul_left = 0, n_mem_cycles = 0;
    logic m_err = 1'b0, n_err = 1'b0;
    logic [3:0] e_stall, e_flush;
    logic [1:0] e_fa, e_fb;
    logic       e_done;

    function automatic logic hit(input logic [REG_BITS-1:0] idx, input logic [REG_BITS-1:0] dest, input logic we);
        return we && idx == dest && !(ZERO_REG != 0 && idx == 0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] idx);
        if (hit(idx, WriteRegM, RegWriteM)) return 2'b10;
        if (hit(idx, WriteRegW, RegWriteW)) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_mul_left   <= 0;
            m_mem_cycles <= 0;
            m_err        <= 1'b0;
        end else begin
            m_mul_left   <= n_mul_left;
            m_mem_cycles <= n_mem_cycles;
            m_err        <= n_err;
        end
    end

    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            e_stall = 4'b0; e_flush = 4'b0; e_fa = 2'b00; e_fb = 2'b00; e_done = 1'b0;
            n_mul_left = m_mul_left; n_mem_cycles = m_mem_cycles; n_err = m_err;
            if (RST) begin
                e_flush = 4'b1111;
            end else begin
                e_fa = fwd_sel(RsE);
                e_fb = fwd_sel(RtE);
                if (m_mem_cycles == 0 && MemReqM && !MemReadyM && !m_err) begin
                    e_stall = 4'b1111; e_flush[0] = 1'b1;
                    n_mem_cycles = 1; n_mul_left = 0;
                end else if (m_mem_cycles > 0) begin
                    if (MemReadyM) begin
                        n_mem_cycles = 0;
                    end else if (m_mem_cycles == MEM_TIMEOUT) begin
                        n_mem_cycles = 0; n_err = 1'b1;
                    end else begin
                        e_stall = 4'b1111; e_flush[0] = 1'b1;
                        n_mem_cycles = m_mem_cycles + 1;
                    end
                end else if (m_mul_left > 0) begin
                    e_stall = 4'b1110; e_flush[1] = 1'b1;
                    e_done = (m_mul_left == 1);
                    n_mul_left = m_mul_left - 1;
                end else if (MulStartE) begin
                    e_stall = 4'b1110; e_flush[1] = 1'b1;
                    n_mul_left = MUL_LAT - 1;
                end
                if (!e_stall[1]) begin
                    if (BranchTakenE) begin
                        e_flush[3] = 1'b1; e_flush[2] = 1'b1;
                    end else if (m_mem_cycles == 0 && m_mul_left == 0 && MemToRegE &&
                                 (hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE))) begin
                        e_stall[3] = 1'b1; e_stall[2] = 1'b1; e_flush[2] = 1'b1;
                    end
                end
            end
            check_output("stalls",   {4'b0, StallF, StallD, StallE, StallM}, {4'b0, e_stall});
            check_output("flushes",  {4'b0, FlushD, FlushE, FlushM, FlushW}, {4'b0, e_flush});
            check_output("fwd_a",    {6'b0, ForwardAE}, {6'b0, e_fa});
            check_output("fwd_b",    {6'b0, ForwardBE}, {6'b0, e_fb});
            check_output("mul_done", {7'b0, MulDone}, {7'b0, e_done});
            check_output("mem_err",  {7'b0, MemErr}, {7'b0, m_err});
        end
    end

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE, MulStartE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input int ready_pct);
        RST          = ($urandom_range(0, 99) == 0);
        RsD          = REG_BITS'($urandom_range(0, 3));
        RtD          = REG_BITS'($urandom_range(0, 3));
        RsE          = REG_BITS'($urandom_range(0, 3));
        RtE          = REG_BITS'($urandom_range(0, 3));
        WriteRegE    = REG_BITS'($urandom_range(0, 3));
        WriteRegM    = REG_BITS'($urandom_range(0, 3));
        WriteRegW    = REG_BITS'($urandom_range(0, 3));
        RegWriteE    = 1'($urandom_range(0, 1));
        RegWriteM    = 1'($urandom_range(0, 1));
        RegWriteW    = 1'($urandom_range(0, 1));
        MemToRegE    = 1'($urandom_range(0, 1));
        BranchTakenE = ($urandom_range(0, 3) == 0);
        MulStartE    = ($urandom_range(0, 5) == 0);
        MemReqM      = ($urandom_range(0, 3) == 0);
        MemReadyM    = ($urandom_range(0, 99) < ready_pct);
    endtask

    int stall_cnt, done_at;

    initial begin
        clear_inputs();
        RST = 1'b1;
        RegWriteM = 1'b1; WriteRegM = 4'd5; RsE = 4'd5;
        repeat (3) next_cycle();
        @(negedge CLK);
        check_output("rst_flush", {4'b0, FlushD, FlushE, FlushM, FlushW}, 8'h0F);
        check_output("rst_stall", {4'b0, StallF, StallD, StallE, StallM}, 8'h00);
        check_output("rst_fwd",   {4'b0, ForwardAE, ForwardBE}, 8'h00);

        next_cycle(); RST = 1'b0; clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 4'd5; RegWriteW = 1'b1; WriteRegW = 4'd5; RsE = 4'd5; RtE = 4'd0;
        @(negedge CLK);
        check_output("fwd_m_priority", {4'b0, ForwardAE, ForwardBE}, 8'b0000_1000);
        next_cycle(); RegWriteM = 1'b0;
        @(negedge CLK);
        check_output("fwd_from_w", {6'b0, ForwardAE}, 8'd1);
        next_cycle(); RegWriteM = 1'b1; WriteRegM = 4'd0; WriteRegW = 4'd0; RsE = 4'd0;
        @(negedge CLK);
        check_output("fwd_zero_reg", {4'b0, ForwardAE, ForwardBE}, 8'h00);

        next_cycle(); clear_inputs();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 4'd3; RsD = 4'd3;
        @(negedge CLK);
        check_output("load_use", {4'b0, StallF, StallD, FlushE, FlushD}, 8'b0000_1110);
        next_cycle(); clear_inputs();
        @(negedge CLK);
        check_output("after_bubble", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'h00);
        next_cycle();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 4'd3; RsD = 4'd3; BranchTakenE = 1'b1;
        @(negedge CLK);
        check_output("branch_over_lu", {4'b0, StallF, StallD, FlushD, FlushE}, 8'b0000_0011);

        // Plain multiply held in E for its full latency.
        next_cycle(); clear_inputs(); MulStartE = 1'b1;
        stall_cnt = 0; done_at = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            if (StallF && StallD && StallE && FlushM && !StallM) stall_cnt++;
            if (MulDone) done_at = i;
            if (i < 4) next_cycle();
        end
        next_cycle(); MulStartE = 1'b0;
        @(negedge CLK);
        check_output("mul_len", 8'(stall_cnt), 8'd4);
        check_output("mul_done_at", 8'(done_at), 8'd4);
        check_output("mul_released", {5'b0, StallF, StallD, StallE}, 8'h00);

        next_cycle(); MemReqM = 1'b1; MemReadyM = 1'b0; stall_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            if (StallF && StallD && StallE && StallM && FlushW) stall_cnt++;
            next_cycle();
        end
        MemReadyM = 1'b1;
        @(negedge CLK);
        check_output("mem_len", 8'(stall_cnt), 8'd3);
        check_output("mem_release", {3'b0, StallF, StallD, StallE, StallM, FlushW}, 8'h00);

        // Memory wait lands in multiply cycle 2; the multiply must rerun from scratch.
        next_cycle(); clear_inputs(); MulStartE = 1'b1;
        next_cycle(); MemReqM = 1'b1;
        next_cycle();
        next_cycle(); MemReadyM = 1'b1;
        @(negedge CLK);
        check_output("mul_int_release", {7'b0, StallE}, 8'h00);
        next_cycle(); MemReqM = 1'b0; MemReadyM = 1'b0;
        stall_cnt = 0; done_at = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            if (StallF && StallD && StallE && FlushM) stall_cnt++;
            if (MulDone) done_at = i;
            if (i < 4) next_cycle();
        end
        next_cycle(); MulStartE = 1'b0;
        check_output("mul_restart_len", 8'(stall_cnt), 8'd4);
        check_output("mul_restart_done", 8'(done_at), 8'd4);

        next_cycle(); MemReqM = 1'b1; MemReadyM = 1'b0; stall_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLK);
            if (StallM) stall_cnt++;
            next_cycle();
        end
        @(negedge CLK);
        check_output("timeout_len", 8'(stall_cnt), 8'd16);
        check_output("mem_err_set", {7'b0, MemErr}, 8'd1);
        check_output("err_no_stall", {7'b0, StallM}, 8'd0);
        next_cycle(); RST = 1'b1; MemReqM = 1'b0;
        next_cycle(); RST = 1'b0;
        @(negedge CLK);
        check_output("rst_clears_err", {7'b0, MemErr}, 8'd0);

        next_cycle(); MulStartE = 1'b1;
        next_cycle();
        next_cycle(); RST = 1'b1;
        @(negedge CLK);
        check_output("rst_mid_mul", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'h0F);
        check_output("rst_mid_mul_done", {7'b0, MulDone}, 8'd0);
        next_cycle(); RST = 1'b0;
        stall_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            if (StallE && FlushM) stall_cnt++;
            next_cycle();
        end
        MulStartE = 1'b0;
        check_output("mul_after_rst_len", 8'(stall_cnt), 8'd4);

        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            apply_stimulus(70);
        end
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            apply_stimulus(5);
        end

        next_cycle(); clear_inputs(); RST = 1'b0;
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline (F, D, E, M, W). It generates the stall and flush controls for every inter-stage register, including StallD/CLR of the F->D register. It also generates the E-stage forwarding selects. It sequences two multi-cycle events: an iterative multiply in E and a wait-stated data-memory access in M, the latter with a timeout guard.

Parameters:
REG_BITS, 4, width of register-index fields
MUL_LAT, 4, total cycles a multiply occupies E (legal range 2..15)
MEM_TIMEOUT, 16, max consecutive wait cycles on a memory access before error (legal range 1..255)
ZERO_REG, 1, if 1, register index 0 never matches for forwarding or hazards

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
RsD, RtD  in  REG_BITS  source register indices in D
RsE, RtE  in  REG_BITS  source register indices in E
WriteRegE, WriteRegM, WriteRegW  in  REG_BITS  destination indices per stage
RegWriteE, RegWriteM, RegWriteW  in  1  destination-write enables per stage
MemToRegE  in  1  instruction in E is a load
BranchTakenE  in  1  taken branch/PC redirect resolved in E
MulStartE  in  1  instruction in E is a multiply
MemReqM  in  1  M-stage memory access active
MemReadyM  in  1  memory completes access this cycle
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushM, FlushW  out  1  clear the corresponding pipeline register (bubble)
ForwardAE, ForwardBE  out  2  E operand select: 00 regfile, 01 from W, 10 from M
MulDone  out  1  one-cycle pulse on the last multiply cycle
MemErr  out  1  sticky memory-timeout flag

Behaviour:
- Match rule: indices equal, and the relevant RegWrite is set. With ZERO_REG=1, index 0 never matches.
- Forwarding (combinational, every cycle): ForwardAE=10 if RsE matches M; else 01 if RsE matches W; else 00. ForwardBE uses the same rule with RtE. M has priority over W.
- FSM states: IDLE, MULWAIT, MEMWAIT. There is one counter, width max(clog2(MUL_LAT), clog2(MEM_TIMEOUT+1)).
- Priority each cycle: memory wait > multiply > branch flush > load-use.
- Memory wait:
  - Condition: MemReqM=1, MemReadyM=0, MemErr=0, in IDLE or MULWAIT. State goes to MEMWAIT and the counter loads 1.
  - Outputs: StallF/D/E/M=1 and FlushW=1 in that cycle and in every MEMWAIT cycle.
  - In MEMWAIT with MemReadyM=1: stalls drop in that same cycle and the state goes to IDLE.
  - In MEMWAIT with MemReadyM=0 and counter=MEM_TIMEOUT: MemErr sets, stalls drop, state goes to IDLE.
  - Otherwise the counter increments.
  - When MemErr=1, memory waits are ignored (no stall) until reset.
- Interrupted multiply: if a memory wait interrupts MULWAIT, the multiply counter is discarded. Because E was frozen, MulStartE is still high on return to IDLE, so the multiply restarts from its beginning.
- Multiply:
  - Start: MulStartE=1 in IDLE with no memory wait. StallF/D/E=1 and FlushM=1 in that cycle. State goes to MULWAIT and the counter loads MUL_LAT-2.
  - In MULWAIT: the same stalls and FlushM apply. The counter decrements; at 0, MulDone=1 and the state goes to IDLE.
  - Total stall duration is exactly MUL_LAT cycles. The cycle after the last stall, E advances.
- Branch: BranchTakenE=1 with no E-or-later stall active gives FlushD=1 and FlushE=1. StallF and StallD are not asserted, even if load-use is also true. While E is stalled, the flush is deferred (BranchTakenE stays held by the frozen E).
- Load-use: MemToRegE, RegWriteE, and WriteRegE matching RsD or RtD, in IDLE, with no higher-priority event. Gives StallF=1, StallD=1, FlushE=1 for one cycle. This needs no state: after the bubble, the load is in M and forwarding covers it.
- Outputs not asserted by the rules above are 0.
- Reset (RST=1):
  - State goes to IDLE, the counter to 0, MemErr to 0.
  - While RST=1: all stalls=0, FlushD/E/M/W=1, ForwardAE/BE=00, MulDone=0.
  - Reset mid-MULWAIT or mid-MEMWAIT aborts with no MulDone.
- All state updates happen on posedge CLK; stall/flush outputs are combinational from state and inputs.

Test Plan:
- RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5, RtE=0 (ZERO_REG=1, W writing reg 0 too) -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load in E writing reg 3, RsD=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then all 0. Repeat with BranchTakenE=1 -> FlushD=FlushE=1, StallD=0.
- MUL_LAT=4, MulStartE held high -> StallF/D/E=1 and FlushM=1 for 4 cycles, MulDone in cycle 4, stalls 0 in cycle 5.
- MemReqM=1 with MemReadyM rising after 3 cycles -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, released in the MemReadyM cycle. Memory wait beginning in multiply cycle 2 -> after release, a full 4-cycle multiply restarts.
- MEM_TIMEOUT=16, MemReadyM never asserted -> stall drops after the 16th wait cycle with MemErr=1. A further MemReqM causes no stall. RST clears MemErr.
- RST asserted mid-MULWAIT -> all four flushes=1, stalls=0, no MulDone. After RST drops, FSM is IDLE and a fresh MulStartE gives a full MUL_LAT stall.
